// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: power-up wait, fixed 4-command init, then one
// register write per IDLE visit with SETUP/EN_HI/HOLD/WAIT timing from a single counter.
module lcd_ctrl #(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int EN_HIGH_CYC    = 12,
  parameter int HOLD_CYC       = 2,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(EN_HIGH_CYC, HOLD_CYC)),
                             max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, last;
  logic          cnt_done;
  logic [1:0]    idx, idx_d;
  logic          done_d;
  logic          rs_d;
  logic [7:0]    dat_d;
  logic          slow_cmd;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear and Home need the long execution wait; only as commands, not as characters.
  assign slow_cmd = !o_lcd_rs && (o_lcd_data == 8'h01 || o_lcd_data == 8'h02);

  always_comb begin
    last = '0;
    case (state)
      PWRUP:       last = CW'(POWERUP_CYC - 1);
      INIT, SETUP: last = CW'(SETUP_CYC - 1);
      EN_HI:       last = CW'(EN_HIGH_CYC - 1);
      HOLD:        last = CW'(HOLD_CYC - 1);
      WAIT:        last = slow_cmd ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
      default:     last = '0;
    endcase
  end

  assign cnt_done = (cnt == last);

  // INIT is the setup phase of each init command; user writes use SETUP instead.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    done_d  = o_init_done;
    rs_d    = o_lcd_rs;
    dat_d   = o_lcd_data;
    case (state)
      PWRUP: if (cnt_done) begin
        state_d = INIT;
        idx_d   = 2'd0;
        rs_d    = 1'b0;
        dat_d   = init_cmd(2'd0);
      end
      INIT, SETUP: if (cnt_done) state_d = EN_HI;
      EN_HI:       if (cnt_done) state_d = HOLD;
      HOLD:        if (cnt_done) state_d = WAIT;
      WAIT: if (cnt_done) begin
        if (o_init_done) begin
          state_d = IDLE;
        end else if (idx == 2'd3) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = INIT;
          idx_d   = idx + 2'd1;
          rs_d    = 1'b0;
          dat_d   = init_cmd(idx + 2'd1);
        end
      end
      IDLE: if (i_valid) begin
        state_d = SETUP;
        rs_d    = i_rs;
        dat_d   = i_data;
      end
      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= PWRUP;
      cnt         <= '0;
      idx         <= 2'd0;
      o_init_done <= 1'b0;
      o_lcd_on    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_data  <= 8'h00;
    end else begin
      state       <= state_d;
      cnt         <= (state_d != state || state == IDLE) ? '0 : cnt + CW'(1);
      idx         <= idx_d;
      o_init_done <= done_d;
      o_lcd_on    <= 1'b1;
      o_lcd_en    <= (state_d == EN_HI);
      o_lcd_rs    <= rs_d;
      o_lcd_data  <= dat_d;
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Randomized bench for lcd_ctrl: a per-write elapsed-cycle model predicts EN, bus and ready.
module tb_lcd_ctrl;
  localparam int P_PWR = 20, P_SET = 2, P_EN = 3, P_HOLD = 1, P_CMD = 5, P_CLR = 10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       valid = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;

  // Model of the user-write phase: m_k = cycles since accept, -1 when idle.
  int         m_k = -1;
  int         m_len = 0;
  logic       m_rs = 1'b0;
  logic [7:0] m_dat = 8'h00;

  lcd_ctrl #(
    .POWERUP_CYC(P_PWR), .SETUP_CYC(P_SET), .EN_HIGH_CYC(P_EN),
    .HOLD_CYC(P_HOLD), .CMD_WAIT_CYC(P_CMD), .CLEAR_WAIT_CYC(P_CLR)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_rs(rs), .i_data(data),
    .o_ready(ready), .o_init_done(init_done), .o_lcd_on(lcd_on), .o_lcd_en(lcd_en),
    .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int write_len(input logic r, input logic [7:0] d);
    return P_SET + P_EN + P_HOLD + ((!r && (d == 8'h01 || d == 8'h02)) ? P_CLR : P_CMD);
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 3))
      0:       return 8'h01;
      1:       return 8'h02;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic model_edge(input logic v, input logic r, input logic [7:0] d);
    if (m_k < 0) begin
      if (v) begin
        m_k = 0; m_len = write_len(r, d); m_rs = r; m_dat = d;
      end
    end else begin
      m_k++;
      if (m_k == m_len) m_k = -1;
    end
  endtask

  // Drive inputs mid-cycle, advance the model across the coming edge, sample at the next negedge.
  task automatic step(input logic v, input logic r, input logic [7:0] d);
    valid = v; rs = r; data = d;
    model_edge(v, r, d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (lcd_en !== 1'b0)    begin errors++; $display("FAIL reset_en got=%b exp=0", lcd_en); end
    if (lcd_rs !== 1'b0)    begin errors++; $display("FAIL reset_rs got=%b exp=0", lcd_rs); end
    if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", lcd_data); end
    if (lcd_on !== 1'b0)    begin errors++; $display("FAIL reset_on got=%b exp=0", lcd_on); end
    if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    if (lcd_rw !== 1'b0)    begin errors++; $display("FAIL reset_rw got=%b exp=0", lcd_rw); end
  endtask

  // Releases reset and follows the whole power-up + init sequence edge by edge.
  task automatic test_init_sequence(input bit noisy);
    logic [7:0] cmds [4];
    int st [4];
    int done_at, rel, idx;
    logic exp_en;
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
    st[0] = P_PWR;
    for (int i = 1; i < 4; i++) st[i] = st[i-1] + write_len(1'b0, cmds[i-1]);
    done_at = st[3] + write_len(1'b0, cmds[3]);
    rstn = 1'b1;
    for (int n = 1; n <= done_at; n++) begin
      valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      rs    = 1'($urandom_range(0, 1));
      data  = 8'($urandom);
      @(negedge clk);
      exp_en = 1'b0; idx = -1; rel = 0;
      for (int i = 0; i < 4; i++) begin
        if (n >= st[i] && n < st[i] + write_len(1'b0, cmds[i])) begin
          idx = i; rel = n - st[i];
        end
      end
      if (idx >= 0 && rel >= P_SET && rel < P_SET + P_EN) exp_en = 1'b1;
      checks += 4;
      if (lcd_en !== exp_en) begin
        errors++; $display("FAIL init_en cycle=%0d got=%b exp=%b", n, lcd_en, exp_en);
      end
      if (ready !== (n >= done_at)) begin
        errors++; $display("FAIL init_ready cycle=%0d got=%b exp=%b", n, ready, n >= done_at);
      end
      if (init_done !== (n >= done_at)) begin
        errors++; $display("FAIL init_done cycle=%0d got=%b exp=%b", n, init_done, n >= done_at);
      end
      if (lcd_on !== 1'b1) begin
        errors++; $display("FAIL init_lcd_on cycle=%0d got=%b exp=1", n, lcd_on);
      end
      if (idx >= 0) begin
        checks++;
        if (lcd_data !== cmds[idx] || lcd_rs !== 1'b0) begin
          errors++;
          $display("FAIL init_bus cycle=%0d got=%h/%b exp=%h/0", n, lcd_data, lcd_rs, cmds[idx]);
        end
      end
    end
    valid = 1'b0;
    m_k = -1; m_rs = 1'b0; m_dat = 8'h06;
  endtask

  task automatic test_single_writes();
    logic       t_rs [8];
    logic [7:0] t_dat [8];
    int lat;
    t_rs[0] = 1'b1; t_dat[0] = 8'h41;
    t_rs[1] = 1'b0; t_dat[1] = 8'h01;
    t_rs[2] = 1'b1; t_dat[2] = 8'h01;
    t_rs[3] = 1'b0; t_dat[3] = 8'h02;
    t_rs[4] = 1'b0; t_dat[4] = 8'h80;
    for (int i = 5; i < 8; i++) begin t_rs[i] = 1'($urandom_range(0, 1)); t_dat[i] = rand_byte(); end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, t_rs[i], t_dat[i]);
      lat = -1;
      for (int k = 0; k < 40 && lat < 0; k++) begin
        checks += 3;
        if (lcd_en !== (m_k >= P_SET && m_k < P_SET + P_EN)) begin
          errors++; $display("FAIL write_en w=%0d k=%0d got=%b", i, k, lcd_en);
        end
        if (lcd_data !== m_dat || lcd_rs !== m_rs) begin
          errors++; $display("FAIL write_bus w=%0d k=%0d got=%h/%b exp=%h/%b", i, k, lcd_data, lcd_rs, m_dat, m_rs);
        end
        if (ready !== (m_k < 0)) begin
          errors++; $display("FAIL write_ready w=%0d k=%0d got=%b exp=%b", i, k, ready, m_k < 0);
        end
        if (ready === 1'b1) lat = k;
        else step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      checks++;
      if (lat != write_len(t_rs[i], t_dat[i])) begin
        errors++; $display("FAIL write_latency w=%0d got=%0d exp=%0d", i, lat, write_len(t_rs[i], t_dat[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int writes = 0;
    for (int c = 0; c < 120; c++) begin
      if (m_k < 0) writes++;
      step(c < 100, 1'($urandom_range(0, 1)), rand_byte());
      checks += 3;
      if (lcd_en !== (m_k >= P_SET && m_k < P_SET + P_EN)) begin
        errors++; $display("FAIL b2b_en c=%0d got=%b", c, lcd_en);
      end
      if (lcd_data !== m_dat || lcd_rs !== m_rs) begin
        errors++; $display("FAIL b2b_bus c=%0d got=%h/%b exp=%h/%b", c, lcd_data, lcd_rs, m_dat, m_rs);
      end
      if (ready !== (m_k < 0)) begin
        errors++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, ready, m_k < 0);
      end
    end
    checks++;
    if (writes < 5) begin
      errors++; $display("FAIL b2b_write_count got=%0d exp>=5", writes);
    end
  endtask

  task automatic test_reset_midwrite();
    step(1'b1, 1'b1, 8'h55);
    repeat (P_SET + 1) step(1'b0, 1'b0, 8'h00);
    checks++;
    if (lcd_en !== 1'b1) begin errors++; $display("FAIL midwrite_en_high got=%b exp=1", lcd_en); end
    #2 rstn = 1'b0;
    #1;
    checks += 5;
    if (lcd_en !== 1'b0)    begin errors++; $display("FAIL async_en got=%b exp=0", lcd_en); end
    if (lcd_data !== 8'h00 || lcd_rs !== 1'b0) begin
      errors++; $display("FAIL async_bus got=%h/%b exp=00/0", lcd_data, lcd_rs);
    end
    if (ready !== 1'b0)     begin errors++; $display("FAIL async_ready got=%b exp=0", ready); end
    if (init_done !== 1'b0) begin errors++; $display("FAIL async_init_done got=%b exp=0", init_done); end
    if (lcd_on !== 1'b0)    begin errors++; $display("FAIL async_on got=%b exp=0", lcd_on); end
    repeat (2) @(negedge clk);
    test_init_sequence(1'b1);
  endtask

  initial begin
    test_reset();
    test_init_sequence(1'b0);
    test_single_writes();
    test_back_to_back();
    test_reset_midwrite();
    test_single_writes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter POWERUP_CYC, default 750000, power-on wait before the init sequence (15 ms at 50 MHz).
REQ-002 Parameter SETUP_CYC, default 2, RS/data setup cycles before EN rises.
REQ-003 Parameter EN_HIGH_CYC, default 12, EN high-pulse width in cycles.
REQ-004 Parameter HOLD_CYC, default 2, cycles EN stays low with RS/data held after the EN fall.
REQ-005 Parameter CMD_WAIT_CYC, default 2000, post-write execution wait for normal commands and data.
REQ-006 Parameter CLEAR_WAIT_CYC, default 82000, post-write wait for Clear (0x01) and Home (0x02) commands with RS=0.
REQ-007 i_clk  in  1  clock.
REQ-008 i_rstn  in  1  reset, asynchronous, active-low.
REQ-009 i_valid  in  1  write request from the LSU LCD register path.
REQ-010 i_rs  in  1  0 = command, 1 = character data.
REQ-011 i_data  in  8  byte to write.
REQ-012 o_ready  out  1  request accepted this cycle when i_valid && o_ready.
REQ-013 o_init_done  out  1  init sequence complete.
REQ-014 o_lcd_on  out  1  LCD power enable.
REQ-015 o_lcd_en  out  1  HD44780 EN strobe.
REQ-016 o_lcd_rs  out  1  HD44780 RS.
REQ-017 o_lcd_rw  out  1  HD44780 RW; the block is write-only.
REQ-018 o_lcd_data  out  8  HD44780 DB[7:0].

Function
REQ-019 States SHALL be PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT; a single cycle counter sized to hold the largest parameter SHALL time every state.
REQ-020 PWRUP SHALL last exactly POWERUP_CYC cycles after reset release, then enter INIT.
REQ-021 INIT SHALL issue the commands 0x38, 0x0C, 0x01, 0x06 in order, each with RS=0 and each going through SETUP/EN_HI/HOLD/WAIT.
REQ-022 The WAIT state for init command 0x01 SHALL use CLEAR_WAIT_CYC.
REQ-023 o_init_done SHALL rise on entry to IDLE after the fourth init command and stay 1 until reset.
REQ-024 o_ready SHALL be 1 only in IDLE.
REQ-025 i_valid SHALL be ignored while o_ready=0; requests are not queued and the upstream holds i_valid.
REQ-026 On the accept edge the block SHALL register i_rs and i_data, drive them on o_lcd_rs and o_lcd_data, enter SETUP, and drop o_ready on the next cycle.
REQ-027 SETUP SHALL last SETUP_CYC cycles with o_lcd_en=0.
REQ-028 EN_HI SHALL last EN_HIGH_CYC cycles with o_lcd_en=1.
REQ-029 HOLD SHALL last HOLD_CYC cycles with o_lcd_en=0.
REQ-030 WAIT SHALL last CLEAR_WAIT_CYC cycles if RS=0 and data is 0x01 or 0x02, otherwise CMD_WAIT_CYC cycles; the block then returns to IDLE.
REQ-031 Between accepting a request and returning to IDLE, the cycle count SHALL be exactly SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+wait.
REQ-032 o_lcd_rs and o_lcd_data SHALL remain stable from SETUP through the end of HOLD; they SHALL retain their last value in WAIT and IDLE.
REQ-033 o_lcd_en SHALL be glitch-free and register-driven.
REQ-034 o_lcd_rw SHALL be constant 0.
REQ-035 o_lcd_on SHALL be 1 from the first clock after reset release.
REQ-036 All parameters SHALL be ≥1; the counter SHALL reload on every state entry and SHALL NOT wrap.
REQ-037 An i_valid that is high in IDLE on the same cycle init completes SHALL be accepted no earlier than the first IDLE cycle.

Reset
REQ-038 Asserting i_rstn low SHALL immediately set o_lcd_en=0, o_lcd_rs=0, o_lcd_data=0x00, o_lcd_on=0, o_ready=0, o_init_done=0, state=PWRUP, counter=0.
REQ-039 Reset mid-write, including during EN_HI, SHALL abort the write, deassert EN immediately, and restart from PWRUP with the full init sequence on release.

Verification (bench parameters: POWERUP=20, SETUP=2, EN_HIGH=3, HOLD=1, CMD_WAIT=5, CLEAR_WAIT=10)
REQ-040 Release reset -> o_lcd_en stays 0 for 20 cycles; four EN pulses each 3 cycles wide with data 0x38, 0x0C, 0x01, 0x06; o_init_done=1 and o_ready=1 at cycle 20+4*11+5=69 after release.
REQ-041 In IDLE, i_valid=1, i_rs=1, i_data=0x41 for one cycle -> o_lcd_data=0x41 and o_lcd_rs=1 for 2 cycles before EN rises; EN high 3 cycles; o_ready returns 1 exactly 11 cycles after the accept.
REQ-042 Send i_rs=0, i_data=0x01 -> o_ready returns 16 cycles after the accept; i_rs=1, i_data=0x01 (data, not a command) -> 11 cycles.
REQ-043 Hold i_valid=1 continuously with changing data while busy -> exactly one write per IDLE visit, each accepted value appearing unchanged on o_lcd_data, no EN pulse outside EN_HI.
REQ-044 Assert i_rstn=0 during the second EN_HI cycle of a user write -> o_lcd_en=0 asynchronously; after release the 20-cycle PWRUP and full init sequence repeat before o_ready=1.
REQ-045 i_valid pulses during PWRUP/INIT -> no extra EN pulses; init byte order unchanged.
